i2s_tx: RTL and testbench



---
 rtl/i2s_tx.sv | 88 ++++++++
 tb/tb_i2s_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S master transmitter that sends each mono sample on both channels. Optional I2S_TX_UNDERRUN_MUTE_EN silences underrun frames.
module i2s_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  vld_i,
    output logic                  bclk_o,
    output logic                  lrclk_o,
    output logic                  sdata_o,
    output logic                  underrun_o,
    output logic                  overrun_o
);
    localparam int DIV_W = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
    localparam int POS_W = $clog2(2 * SLOT_WIDTH);
    localparam int IDX_W = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_DIV - 1);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(2 * SLOT_WIDTH - 1);

    logic [DIV_W-1:0]      div;
    logic [POS_W-1:0]      pos;
    logic [POS_W-1:0]      pos_nxt;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] tx;
    logic                  pending;
    logic                  fall;
    logic                  load;
    logic                  sbit;
    int                    slot_bit;

    // Bit-clock fall detection, next slot position and the serial bit it selects
    always_comb begin
        fall     = (div == DIV_MAX) && bclk_o;
        pos_nxt  = (pos == POS_MAX) ? '0 : pos + 1'b1;
        load     = fall && (pos_nxt == '0);
        slot_bit = int'(pos_nxt) % SLOT_WIDTH;
        sbit     = (slot_bit >= 1 && slot_bit <= DATA_WIDTH) ? tx[IDX_W'(DATA_WIDTH - slot_bit)] : 1'b0;
    end

    // Clock division, framing, sample hand-off and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            pos        <= POS_MAX;
            bclk_o     <= 1'b0;
            lrclk_o    <= 1'b0;
            sdata_o    <= 1'b0;
            underrun_o <= 1'b0;
            overrun_o  <= 1'b0;
            hold       <= '0;
            tx         <= '0;
            pending    <= 1'b0;
        end else begin
            underrun_o <= 1'b0;
            overrun_o  <= 1'b0;
            div        <= (div == DIV_MAX) ? '0 : div + 1'b1;
            bclk_o     <= (div == DIV_MAX) ? ~bclk_o : bclk_o;
            if (fall) begin
                pos     <= pos_nxt;
                lrclk_o <= pos_nxt >= POS_W'(SLOT_WIDTH);
                sdata_o <= sbit;
            end
            if (vld_i)
                hold <= data_i;
            if (load) begin
                pending <= 1'b0;
                if (vld_i)
                    tx <= data_i;
                else if (pending)
                    tx <= hold;
                else begin
                    underrun_o <= 1'b1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
                    tx <= '0;
`else
                    tx <= tx;
`endif
                end
            end else if (vld_i) begin
                pending   <= 1'b1;
                overrun_o <= pending;
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench for i2s_tx; a frame-level reference model predicts every sample, flag pulse and serial bit.
module tb_i2s_tx;
    localparam int DW = 16;
    localparam int SW = 32;
    localparam int BD = 4;
    localparam int FR = 4 * SW * BD;

    typedef struct packed {
        logic [DW-1:0] smp;
        logic          und;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vld_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          bclk_o, lrclk_o, sdata_o, underrun_o, overrun_o;

    int            checks = 0;
    int            failures = 0;
    frame_t        fq[$];
    int            ovq[$];
    int            p_off[$];
    logic [DW-1:0] p_val[$];
    int            e;
    bit            first;
    logic [DW-1:0] prev_tx;

    i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BCLK_DIV(BD)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .vld_i(vld_i),
        .bclk_o(bclk_o), .lrclk_o(lrclk_o), .sdata_o(sdata_o),
        .underrun_o(underrun_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Monitor: derives expected pin values from the edge count since reset release
    initial begin : monitor
        int     n;
        int     pos;
        int     sl;
        logic   r;
        logic   und_now;
        logic   ov_now;
        logic   exp_lr;
        logic   exp_sd;
        frame_t cur;
        n = 0;
        exp_lr = 1'b0;
        exp_sd = 1'b0;
        cur = '0;
        forever begin
            @(posedge clk);
            r = rst;
            @(negedge clk);
            if (r) begin
                n = 0;
                exp_lr = 1'b0;
                exp_sd = 1'b0;
                chk("rst_bclk", bclk_o, 1'b0);
                chk("rst_lrclk", lrclk_o, 1'b0);
                chk("rst_sdata", sdata_o, 1'b0);
                chk("rst_underrun", underrun_o, 1'b0);
                chk("rst_overrun", overrun_o, 1'b0);
            end else begin
                n++;
                und_now = 1'b0;
                if (n % (2 * BD) == 0) begin
                    pos = (n / (2 * BD) - 1) % (2 * SW);
                    if (pos == 0) begin
                        if (fq.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL frame_queue at t=%0t: got empty expected a frame", $time);
                        end else begin
                            cur = fq.pop_front();
                            und_now = cur.und;
                        end
                    end
                    exp_lr = pos >= SW;
                    sl = pos % SW;
                    exp_sd = (sl >= 1 && sl <= DW) ? cur.smp[DW-sl] : 1'b0;
                end
                ov_now = ovq.size() > 0 && ovq[0] == n;
                if (ov_now)
                    void'(ovq.pop_front());
                chk("bclk", bclk_o, (n / BD) % 2 == 1);
                chk("lrclk", lrclk_o, exp_lr);
                chk("sdata", sdata_o, exp_sd);
                chk("underrun", underrun_o, und_now);
                chk("overrun", overrun_o, ov_now);
            end
        end
    end

    task automatic drive_edge(input logic v, input logic [DW-1:0] d);
        vld_i = v;
        data_i = d;
        @(posedge clk);
        #1;
        vld_i = 1'b0;
        e++;
    endtask

    task automatic idle(input int k);
        repeat (k) drive_edge(1'b0, DW'($urandom));
    endtask

    task automatic plan(input int o, input logic [DW-1:0] v);
        p_off.push_back(o);
        p_val.push_back(v);
    endtask

    // Drives one load window from the edge after the previous load up to and including the next load
    task automatic run_frame();
        int            w;
        bit            got;
        logic [DW-1:0] last;
        logic          v;
        logic [DW-1:0] d;
        frame_t        f;
        w = first ? 2 * BD : FR;
        first = 1'b0;
        got = 1'b0;
        last = '0;
        for (int o = 1; o <= w; o++) begin
            v = 1'b0;
            d = DW'($urandom);
            if (p_off.size() > 0 && p_off[0] == o) begin
                v = 1'b1;
                d = p_val[0];
                void'(p_off.pop_front());
                void'(p_val.pop_front());
            end
            if (o == w) begin
                if (v)
                    f.smp = d;
                else if (got)
                    f.smp = last;
                else
`ifdef I2S_TX_UNDERRUN_MUTE_EN
                    f.smp = '0;
`else
                    f.smp = prev_tx;
`endif
                f.und = !v && !got;
                prev_tx = f.smp;
                fq.push_back(f);
            end else if (v) begin
                if (got)
                    ovq.push_back(e + 1);
                got = 1'b1;
                last = d;
            end
            drive_edge(v, d);
        end
        p_off.delete();
        p_val.delete();
    endtask

    initial begin : stimulus
        e = 0;
        first = 1'b1;
        prev_tx = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame();
        run_frame();
        plan(100, 16'hA5C3);
        run_frame();
        plan(50, 16'h1234);
        plan(300, 16'h5678);
        run_frame();
        plan(FR, 16'h7FFF);
        run_frame();
        run_frame();
        plan(10, 16'h8001);
        run_frame();
        run_frame();
        repeat (8) begin
            int nv;
            nv = $urandom_range(0, 3);
            for (int i = 0; i < nv; i++)
                plan(i * 120 + $urandom_range(1, 100), DW'($urandom));
            if ($urandom_range(0, 3) == 0)
                plan(FR, DW'($urandom));
            run_frame();
        end
        idle(40 * BD);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        e = 0;
        first = 1'b1;
        prev_tx = '0;
        run_frame();
        plan(200, DW'($urandom));
        run_frame();
        idle(FR - 1);
        checks++;
        if (fq.size() != 0 || ovq.size() != 0) begin
            failures++;
            $display("FAIL queues_drained: got frames=%0d overruns=%0d expected 0 and 0", fq.size(), ovq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
